// File: rtl/demux4_pkg.sv
// Shared constants and types for the buffered 1-to-4 stream demultiplexer.
package demux4_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] chan_sel_t;

    localparam logic [NUM_CH-1:0] FULL_RST = 4'b0000;

endpackage

// File: rtl/demux_slot.sv
// One output channel of demux4_buffered: one-entry holding register with fill/drain control.
// Optional per-channel delivery counter built only when DEMUX4_COUNT_EN is defined.
module demux_slot
    import demux4_pkg::*;
#(
    parameter int N   = 1,
    parameter int CW  = 8,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_fill,
    input  logic [N-1:0]  i_data,
    input  logic          i_out_ready,
    output logic          o_full,
    output logic [N-1:0]  o_data,
    output logic          o_slot_ready
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [CW-1:0] o_count
`endif
);

    logic         r_full;
    logic [N-1:0] r_data;
    logic         w_drain;

    assign w_drain      = r_full & i_out_ready;
    assign o_slot_ready = ~r_full | i_out_ready;
    assign o_full       = r_full;
    assign o_data       = r_data;

    // A fill in the same cycle as a drain keeps the slot full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= FULL_RST[IDX];
            r_data <= '0;
        end else begin
            if (i_fill) begin
                r_full <= 1'b1;
                r_data <= i_data;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

`ifdef DEMUX4_COUNT_EN
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
`else
    localparam int unused_cw = CW;
`endif

endmodule

// File: rtl/demux4_buffered.sv
// Buffered 1-to-4 valid/ready demultiplexer; every output is registered in a per-channel slot.
// Define DEMUX4_COUNT_EN to add the per-channel delivered-word counters count0..count3.
module demux4_buffered
    import demux4_pkg::*;
#(
    parameter int N  = 1,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [1:0]    in_switch,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [N-1:0]  out0,
    output logic [N-1:0]  out1,
    output logic [N-1:0]  out2,
    output logic [N-1:0]  out3
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1,
    output logic [CW-1:0] count2,
    output logic [CW-1:0] count3
`endif
);

    chan_sel_t         w_sel;
    logic [NUM_CH-1:0] w_slot_ready;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_fill;
    logic              w_accept;
    logic [N-1:0]      w_data [NUM_CH];
`ifdef DEMUX4_COUNT_EN
    logic [CW-1:0]     w_count [NUM_CH];
`endif

    assign w_sel    = in_switch;
    // Only the addressed slot can stall the input.
    assign in_ready = w_slot_ready[w_sel];
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_fill        = '0;
        w_fill[w_sel] = w_accept;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .N   (N),
            .CW  (CW),
            .IDX (k)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_fill       (w_fill[k]),
            .i_data       (in_data),
            .i_out_ready  (out_ready[k]),
            .o_full       (w_full[k]),
            .o_data       (w_data[k]),
            .o_slot_ready (w_slot_ready[k])
`ifdef DEMUX4_COUNT_EN
            ,
            .o_count      (w_count[k])
`endif
        );
    end

    assign out_valid = w_full;
    assign out0      = w_data[0];
    assign out1      = w_data[1];
    assign out2      = w_data[2];
    assign out3      = w_data[3];

`ifdef DEMUX4_COUNT_EN
    assign count0 = w_count[0];
    assign count1 = w_count[1];
    assign count2 = w_count[2];
    assign count3 = w_count[3];
`endif

endmodule

// File: tb/tb_demux4_buffered.sv
// Directed, table-driven bench for demux4_buffered (N=8, CW=2).
module tb_demux4_buffered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_switch;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out0, out1, out2, out3;
`ifdef DEMUX4_COUNT_EN
    logic [1:0] count0, count1, count2, count3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux4_buffered #(.N(8), .CW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_switch (in_switch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
`ifdef DEMUX4_COUNT_EN
        ,
        .count0    (count0),
        .count1    (count1),
        .count2    (count2),
        .count3    (count3)
`endif
    );

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [31:0] exp_out;   // {out3, out2, out1, out0} after the edge
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check in_ready before the edge and registered outputs after it.
    task automatic step(input string name, input vec_t t);
        in_valid  = t.v;
        in_switch = t.s;
        in_data   = t.d;
        out_ready = t.ordy;
        #2;
        check({name, " in_ready"}, {31'd0, in_ready}, {31'd0, t.exp_ir});
        @(posedge clk);
        #1;
        check({name, " out_valid"}, {28'd0, out_valid}, {28'd0, t.exp_ov});
        check({name, " outs"}, {out3, out2, out1, out0}, t.exp_out);
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [7:0] d,
                                input logic [3:0] ordy, input logic ir, input logic [3:0] ov,
                                input logic [31:0] outs);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ordy = ordy;
        r.exp_ir = ir; r.exp_ov = ov; r.exp_out = outs;
        return r;
    endfunction

    initial begin
        // Route/stall, drain, streaming, same-cycle drain+fill, then fill every slot.
        vecs[0]  = mk(1, 2, 8'hA5, 4'b0000, 1, 4'b0100, 32'h00_A5_00_00);
        vecs[1]  = mk(0, 2, 8'h77, 4'b0000, 0, 4'b0100, 32'h00_A5_00_00);
        vecs[2]  = mk(1, 0, 8'h11, 4'b0000, 1, 4'b0101, 32'h00_A5_00_11);
        vecs[3]  = mk(0, 2, 8'h00, 4'b0100, 1, 4'b0001, 32'h00_A5_00_11);
        vecs[4]  = mk(0, 0, 8'h00, 4'b0001, 1, 4'b0000, 32'h00_A5_00_11);
        vecs[5]  = mk(1, 0, 8'h01, 4'b1111, 1, 4'b0001, 32'h00_A5_00_01);
        vecs[6]  = mk(1, 1, 8'h02, 4'b1111, 1, 4'b0010, 32'h00_A5_02_01);
        vecs[7]  = mk(1, 2, 8'h03, 4'b1111, 1, 4'b0100, 32'h00_03_02_01);
        vecs[8]  = mk(1, 3, 8'h04, 4'b1111, 1, 4'b1000, 32'h04_03_02_01);
        vecs[9]  = mk(0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h04_03_02_01);
        vecs[10] = mk(1, 1, 8'h55, 4'b0000, 1, 4'b0010, 32'h04_03_55_01);
        vecs[11] = mk(1, 1, 8'h3C, 4'b0010, 1, 4'b0010, 32'h04_03_3C_01);
        vecs[12] = mk(0, 1, 8'h99, 4'b0000, 0, 4'b0010, 32'h04_03_3C_01);
        vecs[13] = mk(0, 1, 8'h00, 4'b0010, 1, 4'b0000, 32'h04_03_3C_01);
        vecs[14] = mk(1, 0, 8'h10, 4'b0000, 1, 4'b0001, 32'h04_03_3C_10);
        vecs[15] = mk(1, 1, 8'h20, 4'b0000, 1, 4'b0011, 32'h04_03_20_10);
        vecs[16] = mk(1, 2, 8'h30, 4'b0000, 1, 4'b0111, 32'h04_30_20_10);
        vecs[17] = mk(1, 3, 8'h40, 4'b0000, 1, 4'b1111, 32'h40_30_20_10);
        vecs[18] = mk(0, 3, 8'h41, 4'b0000, 0, 4'b1111, 32'h40_30_20_10);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_switch = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'b0000;
        #2;
        check("reset out_valid", {28'd0, out_valid}, 32'd0);
        check("reset outs", {out3, out2, out1, out0}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX4_COUNT_EN
        check("reset counts", {24'd0, count3, count2, count1, count0}, 32'd0);
`endif
        #6;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset with all four slots full, away from any clock edge.
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", {28'd0, out_valid}, 32'd0);
        check("midreset outs", {out3, out2, out1, out0}, 32'd0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        step("postreset idle0", mk(0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h0));
        step("postreset idle1", mk(0, 3, 8'h00, 4'b1111, 1, 4'b0000, 32'h0));
        step("postreset accept", mk(1, 3, 8'h5A, 4'b0000, 1, 4'b1000, 32'h5A_00_00_00));

`ifdef DEMUX4_COUNT_EN
        // Fresh reset, then five drains on channel 3 wrap a 2-bit counter to 1.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("cnt reset", {24'd0, count3, count2, count1, count0}, 32'd0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("cnt word%0d", i),
                 mk(1, 3, 8'(i), 4'b1000, 1, 4'b1000, {8'(i), 24'h0}));
        step("cnt idle", mk(0, 3, 8'h00, 4'b1000, 1, 4'b0000, 32'h05_00_00_00));
        check("count3 wrap", {30'd0, count3}, 32'd1);
        check("count0..2", {26'd0, count2, count1, count0}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
